// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and data-memory wait handling.
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT       = 255,
   parameter int unsigned CNT_W             = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic       ifid_uses_rt,
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rt,
   input  logic       branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifid_flush,
   output logic       idex_write,
   output logic       idex_flush,
   output logic       exmem_write,
   output logic       memwb_write,
   output logic       memwb_bubble,
   output logic       mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
`endif
);

   localparam int unsigned STALL_W = 4;
   localparam logic [CNT_W-1:0]   TIMEOUT   = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]   WAIT_ONE  = CNT_W'(1);
   localparam logic [STALL_W-1:0] STALL_INIT = STALL_W'(LOAD_STALL_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_t;

   state_t             state;
   logic [STALL_W-1:0] stall_cnt;
   logic [CNT_W-1:0]   wait_cnt;
   logic [CNT_W-1:0]   wait_inc;
   logic               ret_stall;
   logic               memstall;
   logic               mem_done;
   logic               loaduse;

   assign memstall = mem_req & ~mem_ready;
   assign mem_done = mem_req & mem_ready;
   assign loaduse  = idex_mem_read & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

   // Wait counter saturates at the timeout value.
   assign wait_inc = (wait_cnt < TIMEOUT) ? wait_cnt + WAIT_ONE : wait_cnt;

   // State, stall/wait counters and the sticky watchdog flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= RUN;
         stall_cnt       <= '0;
         wait_cnt        <= '0;
         ret_stall       <= 1'b0;
         mem_timeout_err <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (memstall) begin
                  wait_cnt  <= WAIT_ONE;
                  ret_stall <= 1'b0;
                  state     <= MEM_WAIT;
                  if (WAIT_ONE >= TIMEOUT) mem_timeout_err <= 1'b1;
               end else if (!branch_taken && loaduse && (LOAD_STALL_CYCLES > 1)) begin
                  stall_cnt <= STALL_INIT;
                  state     <= LOAD_STALL;
               end
            end
            LOAD_STALL: begin
               if (memstall) begin
                  wait_cnt  <= WAIT_ONE;
                  ret_stall <= 1'b1;
                  state     <= MEM_WAIT;
                  if (WAIT_ONE >= TIMEOUT) mem_timeout_err <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt - STALL_W'(1);
                  if (stall_cnt <= STALL_W'(1)) state <= RUN;
               end
            end
            MEM_WAIT: begin
               if (mem_done) begin
                  wait_cnt  <= '0;
                  ret_stall <= 1'b0;
                  state     <= ret_stall ? LOAD_STALL : RUN;
               end else begin
                  wait_cnt <= wait_inc;
                  if (wait_inc >= TIMEOUT) mem_timeout_err <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Pipeline register controls, decoded from state and live hazard inputs.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_flush   = 1'b0;
      exmem_write  = 1'b1;
      memwb_write  = 1'b1;
      memwb_bubble = 1'b0;
      if (reset) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_write   = 1'b0;
         idex_flush   = 1'b1;
         exmem_write  = 1'b0;
         memwb_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (memstall) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_write  = 1'b0;
                  memwb_bubble = 1'b1;
               end else if (branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (loaduse) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end
            end
            LOAD_STALL: begin
               if (memstall) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_write  = 1'b0;
                  memwb_bubble = 1'b1;
               end else begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!mem_done) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_write  = 1'b0;
                  memwb_bubble = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic flush_evt;
   assign flush_evt = (state == RUN) & ~memstall & branch_taken;

   // Saturating performance counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_write && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_evt && !(&flush_count))  flush_count  <= flush_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two instances (1-cycle / 3-cycle load stall, 255 / 8 memory timeout) share one stimulus.
module tb_pipeline_hazard_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
   logic       ifid_uses_rt = 1'b0, idex_mem_read = 1'b0, branch_taken = 1'b0;
   logic       mem_req = 1'b0, mem_ready = 1'b0;

   logic pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a, mww_a, mwb_a, err_a;
   logic pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b, mww_b, mwb_b, err_b;
   logic [7:0] out_a, out_b;

   int errors = 0;
   int checks = 0;

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_write, memwb_bubble}
   localparam logic [7:0] NORM = 8'b1101_0110;
   localparam logic [7:0] RST  = 8'b0010_1001;
   localparam logic [7:0] LU   = 8'b0001_1110;
   localparam logic [7:0] BR   = 8'b1111_1110;
   localparam logic [7:0] FRZ  = 8'b0000_0011;

   always #5 clock = ~clock;

   assign out_a = {pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a, mww_a, mwb_a};
   assign out_b = {pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b, mww_b, mwb_b};

   pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
      .clock(clock), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pcw_a), .ifid_write(ifw_a), .ifid_flush(iff_a), .idex_write(idw_a),
      .idex_flush(idf_a), .exmem_write(exw_a), .memwb_write(mww_a), .memwb_bubble(mwb_a),
      .mem_timeout_err(err_a));

   pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut_b (
      .clock(clock), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pcw_b), .ifid_write(ifw_b), .ifid_flush(iff_b), .idex_write(idw_b),
      .idex_flush(idf_b), .exmem_write(exw_b), .memwb_write(mww_b), .memwb_bubble(mwb_b),
      .mem_timeout_err(err_b));

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Sample both instances at the falling edge, then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [7:0] exp_a, input logic [7:0] exp_b);
      @(negedge clock);
      check({tag, "_a"}, out_a, exp_a);
      check({tag, "_b"}, out_b, exp_b);
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
      ifid_uses_rt = 1'b0; idex_mem_read = 1'b0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_loaduse();
      idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
   endtask

   initial begin
      // Reset state
      cyc("reset", RST, RST);
      check("reset_err", {7'd0, err_b}, 8'd0);
      reset = 1'b0;
      cyc("idle", NORM, NORM);

      // Load-use: 1 stall cycle on a, exactly 3 on b
      set_loaduse();
      cyc("lu1", LU, LU);
      clear_inputs();
      cyc("lu2", NORM, LU);
      cyc("lu3", NORM, LU);
      cyc("lu4", NORM, NORM);

      // No false stalls
      idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
      cyc("r0", NORM, NORM);
      idex_rt = 5'd9; ifid_rt = 5'd9; ifid_rs = 5'd1; ifid_uses_rt = 1'b0;
      cyc("no_rt", NORM, NORM);
      ifid_uses_rt = 1'b1;
      cyc("rt_hit", LU, LU);
      clear_inputs();
      cyc("rt_hit2", NORM, LU);
      cyc("rt_hit3", NORM, LU);
      cyc("rt_hit4", NORM, NORM);

      // Branch beats load-use, no stall afterwards
      set_loaduse(); branch_taken = 1'b1;
      cyc("br_lu", BR, BR);
      clear_inputs();
      cyc("br_after", NORM, NORM);

      // Four memory wait cycles, branch ignored while waiting, then release
      mem_req = 1'b1;
      cyc("mw1", FRZ, FRZ);
      cyc("mw2", FRZ, FRZ);
      branch_taken = 1'b1;
      cyc("mw3_br", FRZ, FRZ);
      branch_taken = 1'b0;
      cyc("mw4", FRZ, FRZ);
      mem_ready = 1'b1;
      cyc("mw_rel", NORM, NORM);
      check("mw_err", {6'd0, err_a, err_b}, 8'd0);
      mem_req = 1'b0;
      cyc("rdy_noreq", NORM, NORM);
      clear_inputs();

      // Watchdog on b after 8 wait cycles, sticky past release
      mem_req = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         check($sformatf("to_err%0d", k), {7'd0, err_b}, (k == 9) ? 8'd1 : 8'd0);
         check($sformatf("to_frz%0d", k), out_b, FRZ);
         @(posedge clock);
         #1;
      end
      mem_ready = 1'b1;
      cyc("to_rel", NORM, NORM);
      clear_inputs();
      cyc("to_idle", NORM, NORM);
      check("to_sticky", {6'd0, err_a, err_b}, 8'd1);

      // Memory wait inside a load stall resumes the remaining stall cycles
      set_loaduse();
      cyc("ls_lu", LU, LU);
      clear_inputs();
      mem_req = 1'b1;
      cyc("ls_mw", FRZ, FRZ);
      mem_ready = 1'b1;
      cyc("ls_rel", NORM, NORM);
      clear_inputs();
      cyc("ls_res1", NORM, LU);
      cyc("ls_res2", NORM, LU);
      cyc("ls_done", NORM, NORM);

      // Reset clears the sticky error
      reset = 1'b1;
      cyc("rst2", RST, RST);
      reset = 1'b0;
      check("err_clr", {6'd0, err_a, err_b}, 8'd0);

      // Reset during the second load-stall cycle aborts the stall
      set_loaduse();
      cyc("rls1", LU, LU);
      clear_inputs();
      reset = 1'b1;
      cyc("rls_rst", RST, RST);
      reset = 1'b0;
      cyc("rls_after1", NORM, NORM);
      cyc("rls_after2", NORM, NORM);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives write-enables and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken branches (resolved in EX) and multi-cycle data-memory waits, with a memory timeout watchdog.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- MEM_TIMEOUT, 255, max MEM_WAIT cycles before error (1..65535).
- CNT_W, 16, width of the timeout counter and optional perf counters.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifid_rs  in  5  rs of instruction in ID.
- ifid_rt  in  5  rt of instruction in ID.
- ifid_uses_rt  in  1  ID instruction reads rt as a source.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rt  in  5  load destination in EX.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_write  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads bubble (all controls 0).
- exmem_write  out  1  EX/MEM load enable.
- memwb_write  out  1  MEM/WB load enable.
- memwb_bubble  out  1  MEM/WB captures MemToReg=0, RegWrite=0.
- mem_timeout_err  out  1  sticky watchdog error.

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT. State and counters are registered; outputs are combinational from state and inputs.
- reset asserted: state=RUN, stall_cnt=0, wait_cnt=0, mem_timeout_err=0.
- During reset, outputs are forced: all *_write=0, ifid_flush=1, idex_flush=1, memwb_bubble=1.
- Default (no event): all *_write=1, flush/bubble=0.
- Hazard terms:
  - memstall = mem_req & ~mem_ready.
  - loaduse = idex_mem_read & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- Priority: memstall > branch_taken > loaduse.
- RUN, memstall:
  - pc/ifid/idex/exmem_write=0, memwb_write=1, memwb_bubble=1.
  - wait_cnt<=1, go to MEM_WAIT.
- RUN, branch_taken (no memstall):
  - ifid_flush=1, idex_flush=1, pc_write=1. Stay in RUN.
  - A coincident loaduse is discarded.
- RUN, loaduse only:
  - pc_write=0, ifid_write=0, idex_flush=1.
  - If LOAD_STALL_CYCLES>1: stall_cnt<=LOAD_STALL_CYCLES-1, go to LOAD_STALL. Otherwise stay in RUN.
- LOAD_STALL:
  - Same outputs as the loaduse case; stall_cnt decrements each cycle; go to RUN when stall_cnt==1.
  - memstall in this state takes priority: go to MEM_WAIT, and stall_cnt is kept and resumed afterwards via a saved return flag.
- MEM_WAIT:
  - Freeze outputs as above while ~mem_ready; wait_cnt increments, saturating at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT: set mem_timeout_err (sticky until reset) and remain in MEM_WAIT.
  - On mem_ready: that cycle all writes=1, memwb_bubble=0; return to RUN, or to LOAD_STALL if the return flag is set.
- branch_taken during MEM_WAIT is ignored; EX is frozen, so the branch re-presents and is acted on in the first RUN cycle.
- mem_ready without mem_req is ignored.
- Reset mid-stall aborts immediately to RUN with no residual stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[CNT_W-1:0] and flush_count[CNT_W-1:0].
  - stall_cycles increments every cycle pc_write=0.
  - flush_count increments every branch flush.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports absent, no counter logic.

Test Plan:
- Load-use: idex_mem_read=1, idex_rt=8, ifid_rs=8 -> 1 cycle of pc_write=0, ifid_write=0, idex_flush=1, then normal. With LOAD_STALL_CYCLES=3 -> exactly 3 such cycles.
- No false stall: idex_rt=0, ifid_rs=0, idex_mem_read=1 -> pc_write=1. ifid_uses_rt=0, idex_rt=ifid_rt=9 -> no stall.
- Branch plus load-use in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1, no stall cycle.
- mem_req=1, mem_ready low 4 cycles -> 4 cycles with pc/ifid/idex/exmem_write=0 and memwb_bubble=1; 5th cycle all writes=1.
- MEM_TIMEOUT=8, mem_ready held 0 -> mem_timeout_err rises after 8 wait cycles and stays 1 after mem_ready; cleared only by reset.
- Assert reset during LOAD_STALL (LOAD_STALL_CYCLES=3, cycle 2) -> outputs at reset values immediately; after release, pc_write=1 on the first edge.
